// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: memory-op codes, data-memory FSM states
// and load/store classification helpers.
package mips_pkg;

   localparam int MEM_OP_W = 4;

   localparam logic [MEM_OP_W-1:0] MEM_NONE = 4'd0;
   localparam logic [MEM_OP_W-1:0] MEM_LW   = 4'd1;
   localparam logic [MEM_OP_W-1:0] MEM_LH   = 4'd2;
   localparam logic [MEM_OP_W-1:0] MEM_LHU  = 4'd3;
   localparam logic [MEM_OP_W-1:0] MEM_LB   = 4'd4;
   localparam logic [MEM_OP_W-1:0] MEM_LBU  = 4'd5;
   localparam logic [MEM_OP_W-1:0] MEM_SW   = 4'd6;
   localparam logic [MEM_OP_W-1:0] MEM_SH   = 4'd7;
   localparam logic [MEM_OP_W-1:0] MEM_SB   = 4'd8;

   typedef enum logic {
      DM_CLEAR = 1'b0,
      DM_IDLE  = 1'b1
   } dm_state_e;

   function automatic logic is_load(input logic [MEM_OP_W-1:0] op);
      return (op >= MEM_LW) && (op <= MEM_LBU);
   endfunction

   function automatic logic is_store(input logic [MEM_OP_W-1:0] op);
      return (op >= MEM_SW) && (op <= MEM_SB);
   endfunction

endpackage

// File: rtl/dm_load_ext.sv
// Load lane select and sign/zero extension for the M-stage data memory.
module dm_load_ext
   import mips_pkg::*;
(
   input  logic [31:0]         word,
   input  logic [1:0]          byte_sel,
   input  logic [MEM_OP_W-1:0] mem_op,
   output logic [31:0]         data
);

   logic [15:0] half_v;
   logic [7:0]  byte_v;

   always_comb begin
      half_v = byte_sel[1] ? word[31:16] : word[15:0];
      byte_v = word[8*byte_sel +: 8];
      data   = '0;
      case (mem_op)
         MEM_LW:  data = word;
         MEM_LH:  data = {{16{half_v[15]}}, half_v};
         MEM_LHU: data = {16'h0000, half_v};
         MEM_LB:  data = {{24{byte_v[7]}}, byte_v};
         MEM_LBU: data = {24'h000000, byte_v};
         default: data = '0;
      endcase
   end

endmodule

// File: rtl/m_stage_dm.sv
// M-stage data memory with post-reset clear sweep and address-error detection.
// Optional store trace enabled by defining DM_TRACE_EN.
module m_stage_dm
   import mips_pkg::*;
#(
   parameter int          DEPTH     = 4096,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
)
(
   input  logic                clk,
   input  logic                reset,
   input  logic                en,
   input  logic [31:0]         M_pc,
   input  logic [MEM_OP_W-1:0] mem_op,
   input  logic [31:0]         addr,
   input  logic [31:0]         wdata,
   output logic [31:0]         M_DM_RD,
   output logic                exc_adel,
   output logic                exc_ades,
   output logic                busy
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

   dm_state_e   state_q, state_d;
   logic [AW-1:0] ptr_q, ptr_d;
   logic [31:0] mem_q [DEPTH];

   logic [31:0]   offset;
   logic [29:0]   word_off;
   logic [AW-1:0] idx;
   logic          out_of_range, misaligned, addr_err;
   logic          op_load, op_store, store_commit;
   logic [31:0]   rd_word, ext_data, st_lanes, merged;
   logic [3:0]    byte_en;
   logic          wr_en;
   logic [AW-1:0] wr_idx;
   logic [31:0]   wr_data;

   always_comb begin
      offset       = addr - BASE_ADDR;
      word_off     = offset[31:2];
      idx          = offset[AW+1:2];
      out_of_range = (addr < BASE_ADDR) || ({2'b00, word_off} >= 32'(DEPTH));
      case (mem_op)
         MEM_LW, MEM_SW:          misaligned = (addr[1:0] != 2'b00);
         MEM_LH, MEM_LHU, MEM_SH: misaligned = addr[0];
         default:                 misaligned = 1'b0;
      endcase
      addr_err = misaligned || out_of_range;
      op_load  = is_load(mem_op);
      op_store = is_store(mem_op);
   end

   assign busy     = (state_q == DM_CLEAR);
   assign exc_adel = !busy && op_load && addr_err;
   assign exc_ades = !busy && op_store && addr_err;

   // Combinational read: a store in this cycle is seen only from the next one.
   assign rd_word = mem_q[idx];

   dm_load_ext u_load_ext (
      .word     (rd_word),
      .byte_sel (addr[1:0]),
      .mem_op   (mem_op),
      .data     (ext_data)
   );

   assign M_DM_RD = (!busy && op_load && !addr_err) ? ext_data : 32'h0000_0000;

   always_comb begin
      byte_en  = 4'b0000;
      st_lanes = wdata;
      case (mem_op)
         MEM_SW: byte_en = 4'b1111;
         MEM_SH: begin
            byte_en  = addr[1] ? 4'b1100 : 4'b0011;
            st_lanes = {2{wdata[15:0]}};
         end
         MEM_SB: begin
            byte_en  = 4'b0001 << addr[1:0];
            st_lanes = {4{wdata[7:0]}};
         end
         default: byte_en = 4'b0000;
      endcase
   end

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_merge
         assign merged[8*gi +: 8] = byte_en[gi] ? st_lanes[8*gi +: 8] : rd_word[8*gi +: 8];
      end
   endgenerate

   assign store_commit = reset && !busy && en && op_store && !addr_err;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      wr_en   = 1'b0;
      wr_idx  = idx;
      wr_data = merged;
      case (state_q)
         DM_CLEAR: begin
            wr_en   = reset;
            wr_idx  = ptr_q;
            wr_data = '0;
            ptr_d   = ptr_q + AW'(1);
            if (ptr_q == LAST_IDX) begin
               state_d = DM_IDLE;
               ptr_d   = '0;
            end
         end
         DM_IDLE: wr_en = store_commit;
         default: begin
            state_d = DM_CLEAR;
            ptr_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= DM_CLEAR;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_idx] <= wr_data;
   end

   logic unused_bits;
`ifdef DM_TRACE_EN
   always_ff @(posedge clk) begin
      if (store_commit)
         $display("%d@%h: *%h <= %h", $time, M_pc, {addr[31:2], 2'b00}, merged);
   end
   assign unused_bits = ^offset[1:0];
`else
   assign unused_bits = ^{offset[1:0], M_pc};
`endif

endmodule

// File: doc/m_stage_dm.md
Name: m_stage_dm

Overview:
- Memory-stage data memory of the 5-stage MIPS pipeline.
- Sits between the EM and MW pipeline registers.
  - Takes address and store data from M-stage.
  - Produces the extended load word `M_DM_RD` that the MW register latches.
  - Flags address exceptions.
- After reset, a sweep FSM clears the whole array one word per cycle and asserts `busy`; hazard control stalls the pipeline on `busy`.

Parameters:
- DEPTH, 4096, number of 32-bit words (power of two).
- BASE_ADDR, 32'h0000_0000, byte address of word 0.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- en  in  1  pipeline advance; stores commit only when en=1.
- M_pc  in  32  PC of the M-stage instruction (used by the trace feature only).
- mem_op  in  4  access type, code from the shared package.
- addr  in  32  byte address (ALU result).
- wdata  in  32  store data (forwarded rt).
- M_DM_RD  out  32  extended load data.
- exc_adel  out  1  load address error.
- exc_ades  out  1  store address error.
- busy  out  1  clear sweep in progress.

Behaviour:
- mem_op codes: NONE=0, LW=1, LH=2, LHU=3, LB=4, LBU=5, SW=6, SH=7, SB=8. Codes 9-15 are treated as NONE.
- FSM states: CLEAR and IDLE.
  - reset=0 at a clock edge: state<=CLEAR, ptr<=0. This applies mid-sweep or mid-operation; the sweep restarts at word 0.
  - CLEAR: mem[ptr]<=0 each cycle and ptr<=ptr+1. At ptr==DEPTH-1, write that word and go to IDLE.
  - Sweep length is exactly DEPTH cycles after reset deasserts.
- busy is 1 in CLEAR and 0 in IDLE. It is combinational from state, so it is 1 in the cycle reset is sampled low and after.
- While busy=1: all accesses are ignored, M_DM_RD=0, exc_adel=exc_ades=0.
- Word index is `(addr-BASE_ADDR)>>2`.
  - Out of range when `addr<BASE_ADDR` or `index>=DEPTH`.
- Misalignment:
  - LW/SW need addr[1:0]=0.
  - LH/LHU/SH need addr[0]=0.
  - Byte ops have no alignment constraint.
- exc_adel = load op AND (misaligned OR out of range). exc_ades = same condition for store ops. Both are combinational and valid in the same cycle as the inputs.
- Loads are combinational reads of the current array contents.
  - Lane selected by addr[1:0]; halfword lane by addr[1].
  - LH/LB sign-extend; LHU/LBU zero-extend.
  - M_DM_RD=0 on exception or on a non-load op.
- Stores write at posedge only when IDLE, en=1 and no exception.
  - Byte enables: SW=4'b1111; SH=4'b0011 or 4'b1100 by addr[1]; SB one-hot by addr[1:0].
  - Unselected bytes are preserved.
- Read-during-write to the same word: the combinational read in that cycle returns old data; new data is visible from the next cycle.
- Excepting stores never modify memory.
- en=0 suppresses writes only; reads and exceptions are still driven.
- No output register, so there is no added latency.
- Memory contents are undefined only before the first reset. The sweep defines them.

Optional Feature:
- Macro `DM_TRACE_EN`.
- When defined: on every committed store, emit `$display("%d@%h: *%h <= %h", $time, M_pc, word_byte_addr, merged_word)`.
  - word_byte_addr = addr with bits [1:0] cleared.
  - merged_word is the full word after byte-enable merge.
  - Sweep writes are not traced.
- When undefined: no simulation output; synthesized logic is identical.

Decomposition:
- Shared package `mips_pkg` holds:
  - the mem_op code localparams, including the 4-bit width and NONE..SB;
  - the FSM state encoding (CLEAR, IDLE);
  - the helper functions `is_load(op)` and `is_store(op)`.
- One sub-module, `dm_load_ext`: combinational lane select plus sign/zero extension. Inputs: word, addr[1:0], mem_op. Output: 32-bit data.

Test Plan (DEPTH=16, BASE_ADDR=0):
- Sweep: hold reset low 1 cycle then release. busy=1 for exactly 16 cycles then 0. LW of every address 0x00..0x3C returns 0.
- Store width: SW 0x8 data 0x11223344; SB 0x9 data 0xAA; SH 0xA data 0xBEEF. Then:
  - LW 0x8 returns 0xBEEFAA44.
  - LB 0x9 returns 0xFFFFFFAA; LBU 0x9 returns 0x000000AA.
  - LH 0xA returns 0xFFFFBEEF; LHU 0xA returns 0x0000BEEF.
- Exceptions:
  - LW 0x2: exc_adel=1, M_DM_RD=0.
  - SH 0x5: exc_ades=1; word 0x4 is unchanged.
  - SW 0x40: exc_ades=1, no write.
  - LB 0x40: exc_adel=1.
- Stall and hazard:
  - SW 0x0 with en=0: word stays 0.
  - SW 0x0 data 0x5 with en=1: LW 0x0 in the same cycle returns 0; the next cycle returns 5.
- Reset mid-sweep: assert reset at sweep cycle 7 for one cycle. busy stays 1 and the sweep completes 16 cycles after release.
- Store while busy: SW 0x4 data 0x1234 issued during busy. exc_ades=0 and LW 0x4 after sweep returns 0.
